// File: rtl/mips32_multicycle.sv
// Multi-cycle MIPS32 subset core (FETCH/DECODE/EXEC/MEM/WB) with an external instruction memory behind req/valid.
// Register file and data memory are internal; halt, retire count and the illegal-decode flag are reported on ports.
module mips32_multicycle #(
  parameter int          IMEM_AW  = 6,
  parameter int          DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [31:0]        instr,
  output logic               halted,
  output logic [31:0]        halt_value,
  output logic [31:0]        retired,
  output logic               illegal
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu, r_mdr;
  logic [31:0] r_rf   [32];
  logic [31:0] r_dmem [2**DMEM_AW];

  logic [5:0]         w_op, w_funct;
  logic [4:0]         w_rs, w_rt, w_rd, w_sh, w_dst;
  logic [31:0]        w_rs_val, w_rt_val, w_sext, w_pc4, w_br_tgt, w_j_tgt, w_alu, w_wdat;
  logic [DMEM_AW-1:0] w_daddr;
  logic               w_is_r, w_brk, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_j, w_is_illegal;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_sh     = r_ir[10:6];
  assign w_funct  = r_ir[5:0];
  assign w_is_r   = (w_op == 6'h00);
  assign w_brk    = w_is_r && (w_funct == 6'h0D);
  assign w_is_lw  = (w_op == 6'h23);
  assign w_is_sw  = (w_op == 6'h2B);
  assign w_is_beq = (w_op == 6'h04);
  assign w_is_bne = (w_op == 6'h05);
  assign w_is_j   = (w_op == 6'h02);

  // r0 is never written, but reads are forced to zero regardless
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];
  assign w_sext   = {{16{r_ir[15]}}, r_ir[15:0]};

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_tgt = w_pc4 + {r_imm[29:0], 2'b00};
  assign w_j_tgt  = {w_pc4[31:28], r_ir[25:0], 2'b00};
  assign w_daddr  = r_alu[DMEM_AW+1:2];
  assign w_dst    = w_is_r ? w_rd : w_rt;
  assign w_wdat   = w_is_lw ? r_mdr : r_alu;

  assign imem_req  = (r_state == S_FETCH) && !reset;
  assign imem_addr = r_pc[IMEM_AW+1:2];

  always_comb begin
    w_is_illegal = 1'b1;
    if (w_is_r) begin
      case (w_funct)
        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h0D: w_is_illegal = 1'b0;
        default: ;
      endcase
    end else begin
      case (w_op)
        6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02: w_is_illegal = 1'b0;
        default: ;
      endcase
    end
  end

  // addi/lw/sw share the rs+imm path, which is also the default
  always_comb begin
    w_alu = r_a + r_imm;
    if (w_is_r) begin
      case (w_funct)
        6'h20:   w_alu = r_a + r_b;
        6'h22:   w_alu = r_a - r_b;
        6'h24:   w_alu = r_a & r_b;
        6'h25:   w_alu = r_a | r_b;
        6'h2A:   w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
        6'h00:   w_alu = r_b << w_sh;
        6'h02:   w_alu = r_b >> w_sh;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && (r_state == S_MEM) && w_is_sw) begin
      r_dmem[w_daddr] <= r_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_imm      <= '0;
      r_alu      <= '0;
      r_mdr      <= '0;
      halted     <= 1'b0;
      halt_value <= '0;
      retired    <= '0;
      illegal    <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a   <= w_rs_val;
          r_b   <= w_rt_val;
          r_imm <= w_sext;
          if (w_brk) begin
            halted     <= 1'b1;
            halt_value <= w_rs_val;
            retired    <= retired + 32'd1;
            r_state    <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_is_illegal || w_is_beq || w_is_bne || w_is_j) begin
            if (w_is_illegal)                   illegal <= 1'b1;
            if (w_is_illegal)                   r_pc <= w_pc4;
            else if (w_is_j)                    r_pc <= w_j_tgt;
            else if ((r_a == r_b) == w_is_beq)  r_pc <= w_br_tgt;
            else                                r_pc <= w_pc4;
            retired <= retired + 32'd1;
            r_state <= S_FETCH;
          end else if (w_is_lw || w_is_sw) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (w_is_sw) begin
            r_pc    <= w_pc4;
            retired <= retired + 32'd1;
            r_state <= S_FETCH;
          end else begin
            r_mdr   <= r_dmem[w_daddr];
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (w_dst != 5'd0) r_rf[w_dst] <= w_wdat;
          r_pc    <= w_pc4;
          retired <= retired + 32'd1;
          r_state <= S_FETCH;
        end
        S_HALT:  ;
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule
